// File: rtl/regfile_rename_mp_pkg.sv
// regfile_rename_mp_pkg: shared widths for the renaming register file
package regfile_rename_mp_pkg;
    localparam int XLEN           = 32;
    localparam int REG_CNT_WIDTH  = 5;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int DISPATCH_WIDTH = 2;
    localparam int COMMIT_WIDTH   = 2;
endpackage

// File: rtl/regfile_rename_mp_if.sv
// regfile_rename_mp_if: dispatch, commit and operand-read bundle of the renaming register file
interface regfile_rename_mp_if #(
    parameter int XLEN           = regfile_rename_mp_pkg::XLEN,
    parameter int REG_CNT_WIDTH  = regfile_rename_mp_pkg::REG_CNT_WIDTH,
    parameter int ROB_SIZE_WIDTH = regfile_rename_mp_pkg::ROB_SIZE_WIDTH,
    parameter int DISPATCH_WIDTH = regfile_rename_mp_pkg::DISPATCH_WIDTH,
    parameter int COMMIT_WIDTH   = regfile_rename_mp_pkg::COMMIT_WIDTH
);
    logic                                     rdy;
    logic                                     flush;
    logic                                     stall;
    logic [DISPATCH_WIDTH-1:0]                dec_valid;
    logic [DISPATCH_WIDTH-1:0]                dec_wr_en;
    logic [DISPATCH_WIDTH*REG_CNT_WIDTH-1:0]  dec_rd;
    logic [DISPATCH_WIDTH*REG_CNT_WIDTH-1:0]  dec_rs1;
    logic [DISPATCH_WIDTH*REG_CNT_WIDTH-1:0]  dec_rs2;
    logic [DISPATCH_WIDTH*ROB_SIZE_WIDTH-1:0] dec_rob_id;
    logic [COMMIT_WIDTH-1:0]                  cm_valid;
    logic [COMMIT_WIDTH*REG_CNT_WIDTH-1:0]    cm_rd;
    logic [COMMIT_WIDTH*ROB_SIZE_WIDTH-1:0]   cm_rob_id;
    logic [COMMIT_WIDTH*XLEN-1:0]             cm_val;
    logic [DISPATCH_WIDTH*XLEN-1:0]           rf_val1;
    logic [DISPATCH_WIDTH*XLEN-1:0]           rf_val2;
    logic [DISPATCH_WIDTH-1:0]                rf_busy1;
    logic [DISPATCH_WIDTH-1:0]                rf_busy2;
    logic [DISPATCH_WIDTH*ROB_SIZE_WIDTH-1:0] rf_tag1;
    logic [DISPATCH_WIDTH*ROB_SIZE_WIDTH-1:0] rf_tag2;
    modport master (
        output rdy, flush, stall, dec_valid, dec_wr_en, dec_rd, dec_rs1, dec_rs2, dec_rob_id,
        output cm_valid, cm_rd, cm_rob_id, cm_val,
        input  rf_val1, rf_val2, rf_busy1, rf_busy2, rf_tag1, rf_tag2
    );
    modport slave (
        input  rdy, flush, stall, dec_valid, dec_wr_en, dec_rd, dec_rs1, dec_rs2, dec_rob_id,
        input  cm_valid, cm_rd, cm_rob_id, cm_val,
        output rf_val1, rf_val2, rf_busy1, rf_busy2, rf_tag1, rf_tag2
    );
endinterface

// File: rtl/regfile_rename_mp_rf_read_port.sv
// rf_read_port: one source-operand lookup with intra-bundle and commit bypass
module rf_read_port #(
    parameter int XLEN           = regfile_rename_mp_pkg::XLEN,
    parameter int REG_CNT_WIDTH  = regfile_rename_mp_pkg::REG_CNT_WIDTH,
    parameter int ROB_SIZE_WIDTH = regfile_rename_mp_pkg::ROB_SIZE_WIDTH,
    parameter int DISPATCH_WIDTH = regfile_rename_mp_pkg::DISPATCH_WIDTH,
    parameter int COMMIT_WIDTH   = regfile_rename_mp_pkg::COMMIT_WIDTH,
    parameter int SLOT           = 0
) (
    input  logic                                     en_i,
    input  logic [REG_CNT_WIDTH-1:0]                 rs_i,
    input  logic [XLEN-1:0]                          st_val_i,
    input  logic                                     st_busy_i,
    input  logic [ROB_SIZE_WIDTH-1:0]                st_tag_i,
    input  logic [DISPATCH_WIDTH-1:0]                wr_i,
    input  logic [DISPATCH_WIDTH*REG_CNT_WIDTH-1:0]  dec_rd_i,
    input  logic [DISPATCH_WIDTH*ROB_SIZE_WIDTH-1:0] dec_rob_id_i,
    input  logic [COMMIT_WIDTH-1:0]                  cm_valid_i,
    input  logic [COMMIT_WIDTH*REG_CNT_WIDTH-1:0]    cm_rd_i,
    input  logic [COMMIT_WIDTH*ROB_SIZE_WIDTH-1:0]   cm_rob_id_i,
    input  logic [COMMIT_WIDTH*XLEN-1:0]             cm_val_i,
    output logic [XLEN-1:0]                          val_o,
    output logic                                     busy_o,
    output logic [ROB_SIZE_WIDTH-1:0]                tag_o
);
    always_comb begin
        val_o  = st_val_i;
        busy_o = st_busy_i;
        tag_o  = st_tag_i;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            if (cm_valid_i[k] && cm_rd_i[k*REG_CNT_WIDTH +: REG_CNT_WIDTH] == rs_i) begin
                val_o  = cm_val_i[k*XLEN +: XLEN];
                busy_o = st_busy_i && st_tag_i != cm_rob_id_i[k*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
            end
        // only older slots of the same bundle can produce this operand
        for (int j = 0; j < DISPATCH_WIDTH; j++)
            if (j < SLOT && wr_i[j] && dec_rd_i[j*REG_CNT_WIDTH +: REG_CNT_WIDTH] == rs_i) begin
                busy_o = 1'b1;
                tag_o  = dec_rob_id_i[j*ROB_SIZE_WIDTH +: ROB_SIZE_WIDTH];
            end
        if (!en_i || rs_i == '0) begin
            val_o  = '0;
            busy_o = 1'b0;
        end
        tag_o = busy_o ? tag_o : '0;
    end
endmodule

// File: rtl/regfile_rename_mp.sv
// regfile_rename_mp: architectural register file with busy/tag renaming state
// and multi-port dispatch lookup and commit write-back.
module regfile_rename_mp #(
    parameter int XLEN           = regfile_rename_mp_pkg::XLEN,
    parameter int REG_CNT_WIDTH  = regfile_rename_mp_pkg::REG_CNT_WIDTH,
    parameter int ROB_SIZE_WIDTH = regfile_rename_mp_pkg::ROB_SIZE_WIDTH,
    parameter int DISPATCH_WIDTH = regfile_rename_mp_pkg::DISPATCH_WIDTH,
    parameter int COMMIT_WIDTH   = regfile_rename_mp_pkg::COMMIT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    regfile_rename_mp_if.slave  bus
);
    localparam int RW      = REG_CNT_WIDTH;
    localparam int TW      = ROB_SIZE_WIDTH;
    localparam int REG_CNT = 2**RW;

    logic [XLEN-1:0]    val_q [REG_CNT];
    logic [XLEN-1:0]    val_d [REG_CNT];
    logic [TW-1:0]      tag_q [REG_CNT];
    logic [TW-1:0]      tag_d [REG_CNT];
    logic [REG_CNT-1:0] busy_q, busy_d;
    logic [RW-1:0]      cm_rd [COMMIT_WIDTH];
    logic [RW-1:0]      dec_rd [DISPATCH_WIDTH];
    logic [DISPATCH_WIDTH-1:0] wr;

    assign wr = bus.dec_valid & bus.dec_wr_en;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_cm
        assign cm_rd[k] = bus.cm_rd[k*RW +: RW];
    end

    for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : g_dec
        assign dec_rd[s] = bus.dec_rd[s*RW +: RW];
    end

    // later ports/slots overwrite earlier ones; renames land after commits
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.rdy) begin
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (bus.cm_valid[k] && cm_rd[k] != '0) begin
                    val_d[cm_rd[k]]  = bus.cm_val[k*XLEN +: XLEN];
                    busy_d[cm_rd[k]] = busy_q[cm_rd[k]] && tag_q[cm_rd[k]] != bus.cm_rob_id[k*TW +: TW];
                end
            if (bus.flush) begin
                busy_d = '0;
                for (int r = 0; r < REG_CNT; r++) tag_d[r] = '0;
            end else if (!bus.stall) begin
                for (int s = 0; s < DISPATCH_WIDTH; s++)
                    if (wr[s] && dec_rd[s] != '0) begin
                        busy_d[dec_rd[s]] = 1'b1;
                        tag_d[dec_rd[s]]  = bus.dec_rob_id[s*TW +: TW];
                    end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_CNT; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar s = 0; s < DISPATCH_WIDTH; s++) begin : g_rd
        logic [RW-1:0] rs1, rs2;
        assign rs1 = bus.dec_rs1[s*RW +: RW];
        assign rs2 = bus.dec_rs2[s*RW +: RW];
        rf_read_port #(
            .XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(TW),
            .DISPATCH_WIDTH(DISPATCH_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH), .SLOT(s)
        ) u_rs1 (
            .en_i(rst), .rs_i(rs1),
            .st_val_i(val_q[rs1]), .st_busy_i(busy_q[rs1]), .st_tag_i(tag_q[rs1]),
            .wr_i(wr), .dec_rd_i(bus.dec_rd), .dec_rob_id_i(bus.dec_rob_id),
            .cm_valid_i(bus.cm_valid), .cm_rd_i(bus.cm_rd), .cm_rob_id_i(bus.cm_rob_id), .cm_val_i(bus.cm_val),
            .val_o(bus.rf_val1[s*XLEN +: XLEN]), .busy_o(bus.rf_busy1[s]), .tag_o(bus.rf_tag1[s*TW +: TW])
        );
        rf_read_port #(
            .XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(TW),
            .DISPATCH_WIDTH(DISPATCH_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH), .SLOT(s)
        ) u_rs2 (
            .en_i(rst), .rs_i(rs2),
            .st_val_i(val_q[rs2]), .st_busy_i(busy_q[rs2]), .st_tag_i(tag_q[rs2]),
            .wr_i(wr), .dec_rd_i(bus.dec_rd), .dec_rob_id_i(bus.dec_rob_id),
            .cm_valid_i(bus.cm_valid), .cm_rd_i(bus.cm_rd), .cm_rob_id_i(bus.cm_rob_id), .cm_val_i(bus.cm_val),
            .val_o(bus.rf_val2[s*XLEN +: XLEN]), .busy_o(bus.rf_busy2[s]), .tag_o(bus.rf_tag2[s*TW +: TW])
        );
    end
endmodule

// File: tb/tb_regfile_rename_mp.sv
// tb_regfile_rename_mp: directed self-checking bench for the renaming register file
module tb_regfile_rename_mp;
    import regfile_rename_mp_pkg::*;
    localparam int RW = REG_CNT_WIDTH;
    localparam int TW = ROB_SIZE_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_rename_mp_if bus ();
    regfile_rename_mp dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic idle();
        bus.rdy = 1'b1;  bus.flush = 1'b0;  bus.stall = 1'b0;
        bus.dec_valid = '0; bus.dec_wr_en = '0; bus.dec_rd = '0;
        bus.dec_rs1 = '0;   bus.dec_rs2 = '0;   bus.dec_rob_id = '0;
        bus.cm_valid = '0;  bus.cm_rd = '0;     bus.cm_rob_id = '0; bus.cm_val = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic dec(input int s, input logic [RW-1:0] rd, input logic [TW-1:0] id);
        bus.dec_valid[s] = 1'b1;
        bus.dec_wr_en[s] = 1'b1;
        bus.dec_rd[s*RW +: RW] = rd;
        bus.dec_rob_id[s*TW +: TW] = id;
    endtask

    task automatic src(input int s, input logic [RW-1:0] a, input logic [RW-1:0] b);
        bus.dec_rs1[s*RW +: RW] = a;
        bus.dec_rs2[s*RW +: RW] = b;
    endtask

    task automatic cm(input int k, input logic [RW-1:0] rd, input logic [TW-1:0] id, input logic [XLEN-1:0] v);
        bus.cm_valid[k] = 1'b1;
        bus.cm_rd[k*RW +: RW] = rd;
        bus.cm_rob_id[k*TW +: TW] = id;
        bus.cm_val[k*XLEN +: XLEN] = v;
    endtask

    task automatic chk(input string t, input logic [XLEN-1:0] o, input logic [XLEN-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    function automatic logic [XLEN-1:0] v1(input int s); return bus.rf_val1[s*XLEN +: XLEN]; endfunction
    function automatic logic [XLEN-1:0] v2(input int s); return bus.rf_val2[s*XLEN +: XLEN]; endfunction
    function automatic logic [XLEN-1:0] b1(input int s); return {31'b0, bus.rf_busy1[s]}; endfunction
    function automatic logic [XLEN-1:0] b2(input int s); return {31'b0, bus.rf_busy2[s]}; endfunction
    function automatic logic [XLEN-1:0] t1(input int s); return {28'b0, bus.rf_tag1[s*TW +: TW]}; endfunction
    function automatic logic [XLEN-1:0] t2(input int s); return {28'b0, bus.rf_tag2[s*TW +: TW]}; endfunction

    initial begin
        idle();
        // in reset: bypass paths must not leak through
        cm(0, 5'd3, 4'd0, 32'h77);
        dec(0, 5'd3, 4'd5);
        src(0, 5'd3, 5'd0);
        src(1, 5'd3, 5'd3);
        #1;
        chk("rst_val_bypass", v1(0), 32'h0);
        chk("rst_busy_intra", b1(1), 32'h0);
        chk("rst_tag_intra", t1(1), 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_val", v1(0), 32'h0);
        rst = 1'b1;
        idle();

        // rename then commit
        dec(0, 5'd5, 4'd3);
        tick();
        src(0, 5'd5, 5'd0); #1;
        chk("ren_busy", b1(0), 32'h1);
        chk("ren_tag", t1(0), 32'h3);
        cm(0, 5'd5, 4'd3, 32'hAB); #1;
        chk("cm_byp_val", v1(0), 32'hAB);
        chk("cm_byp_busy", b1(0), 32'h0);
        chk("cm_byp_tag", t1(0), 32'h0);
        tick();
        src(0, 5'd5, 5'd0); #1;
        chk("cm_st_val", v1(0), 32'hAB);
        chk("cm_st_busy", b1(0), 32'h0);

        // stale commit
        dec(0, 5'd5, 4'd3);
        tick();
        dec(0, 5'd5, 4'd7);
        tick();
        cm(0, 5'd5, 4'd3, 32'h11);
        src(1, 5'd5, 5'd0); #1;
        chk("stale_byp_busy", b1(1), 32'h1);
        chk("stale_byp_tag", t1(1), 32'h7);
        tick();
        src(0, 5'd5, 5'd0); #1;
        chk("stale_val", v1(0), 32'h11);
        chk("stale_busy", b1(0), 32'h1);
        chk("stale_tag", t1(0), 32'h7);

        // intra-bundle forwarding and same-rd in two slots
        dec(0, 5'd6, 4'd2);
        dec(1, 5'd6, 4'd4);
        src(0, 5'd0, 5'd6);
        src(1, 5'd0, 5'd6); #1;
        chk("intra_busy2", b2(1), 32'h1);
        chk("intra_tag2", t2(1), 32'h2);
        chk("intra_self_busy", b2(0), 32'h0);
        tick();
        src(0, 5'd6, 5'd0); #1;
        chk("two_slot_tag", t1(0), 32'h4);

        // dual commit same rd plus rename in the same cycle
        cm(0, 5'd9, 4'd1, 32'h1);
        cm(1, 5'd9, 4'd1, 32'h2);
        dec(0, 5'd9, 4'd5);
        src(1, 5'd9, 5'd0); #1;
        chk("dual_byp_val", v1(1), 32'h2);
        chk("dual_byp_busy", b1(1), 32'h1);
        chk("dual_byp_tag", t1(1), 32'h5);
        tick();
        src(0, 5'd9, 5'd0); #1;
        chk("dual_val", v1(0), 32'h2);
        chk("dual_busy", b1(0), 32'h1);
        chk("dual_tag", t1(0), 32'h5);

        // flush with concurrent commit and rename
        bus.flush = 1'b1;
        cm(0, 5'd4, 4'd0, 32'h55);
        dec(0, 5'd8, 4'd6);
        tick();
        src(0, 5'd4, 5'd8);
        src(1, 5'd5, 5'd9); #1;
        chk("fl_x4_val", v1(0), 32'h55);
        chk("fl_x8_busy", b2(0), 32'h0);
        chk("fl_x5_busy", b1(1), 32'h0);
        chk("fl_x5_tag", t1(1), 32'h0);
        chk("fl_x5_val", v1(1), 32'h11);
        chk("fl_x9_busy", b2(1), 32'h0);

        // clock enable low holds all state
        dec(0, 5'd10, 4'd2);
        tick();
        bus.rdy = 1'b0;
        cm(0, 5'd10, 4'd2, 32'h99);
        dec(0, 5'd11, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        idle();
        src(0, 5'd10, 5'd11); #1;
        chk("rdy_x10_val", v1(0), 32'h0);
        chk("rdy_x10_busy", b1(0), 32'h1);
        chk("rdy_x10_tag", t1(0), 32'h2);
        chk("rdy_x11_busy", b2(0), 32'h0);

        // x0 is never written
        cm(0, 5'd0, 4'd0, 32'hFF);
        dec(0, 5'd0, 4'd1);
        src(1, 5'd0, 5'd0); #1;
        chk("x0_byp_val", v1(1), 32'h0);
        chk("x0_byp_busy", b1(1), 32'h0);
        tick();
        src(0, 5'd0, 5'd0); #1;
        chk("x0_val", v1(0), 32'h0);
        chk("x0_busy", b1(0), 32'h0);

        // stall blocks renames but not commits or reads
        bus.stall = 1'b1;
        dec(0, 5'd12, 4'd1);
        cm(0, 5'd13, 4'd0, 32'h42);
        src(1, 5'd13, 5'd0); #1;
        chk("stall_byp_val", v1(1), 32'h42);
        tick();
        src(0, 5'd12, 5'd13); #1;
        chk("stall_x12_busy", b1(0), 32'h0);
        chk("stall_x13_val", v2(0), 32'h42);

        // asynchronous reset mid-run
        src(0, 5'd9, 5'd0);
        src(1, 5'd0, 5'd10); #1;
        chk("pre_rst_val", v1(0), 32'h2);
        chk("pre_rst_busy", b2(1), 32'h1);
        rst = 1'b0; #1;
        chk("mid_rst_val", v1(0), 32'h0);
        chk("mid_rst_busy", b2(1), 32'h0);
        chk("mid_rst_tag", t2(1), 32'h0);
        rst = 1'b1;
        idle();
        dec(0, 5'd7, 4'd9);
        tick();
        src(0, 5'd7, 5'd10); #1;
        chk("post_rst_busy", b1(0), 32'h1);
        chk("post_rst_tag", t1(0), 32'h9);
        chk("post_rst_x10", b2(0), 32'h0);
        chk("post_rst_x9", v1(1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_rename_mp.md
REGFILE_RENAME_MP -- requirements
Module: regfile_rename_mp

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, register data width
- REG_CNT_WIDTH, 5, architectural register index width; REG_CNT = 2**REG_CNT_WIDTH
- ROB_SIZE_WIDTH, 4, ROB tag width
- DISPATCH_WIDTH, 2, decoded instructions accepted per cycle
- COMMIT_WIDTH, 2, ROB retirement ports per cycle

REQ-002 Ports (name, direction, width, meaning); clock and reset first, clock enable after:
- clk, in, 1, the single clock
- rst, in, 1, reset, asynchronous, active-low
- rdy, in, 1, clock enable; all state holds while low
- flush, in, 1, discard all pending renames
- stall, in, 1, block dispatch renames
- dec_valid, in, DISPATCH_WIDTH, slot valid
- dec_wr_en, in, DISPATCH_WIDTH, slot writes rd (low for branch/store)
- dec_rd, in, DISPATCH_WIDTH*REG_CNT_WIDTH, slot destination
- dec_rs1 / dec_rs2, in, DISPATCH_WIDTH*REG_CNT_WIDTH each, slot sources
- dec_rob_id, in, DISPATCH_WIDTH*ROB_SIZE_WIDTH, ROB tag allocated to slot
- cm_valid, in, COMMIT_WIDTH, commit port valid
- cm_rd, in, COMMIT_WIDTH*REG_CNT_WIDTH, committed destination
- cm_rob_id, in, COMMIT_WIDTH*ROB_SIZE_WIDTH, committed tag
- cm_val, in, COMMIT_WIDTH*XLEN, committed value
- rf_val1 / rf_val2, out, DISPATCH_WIDTH*XLEN each, source operand values
- rf_busy1 / rf_busy2, out, DISPATCH_WIDTH each, source still pending
- rf_tag1 / rf_tag2, out, DISPATCH_WIDTH*ROB_SIZE_WIDTH each, producer tag; 0 when not busy

Function
REQ-003 State per register: val[XLEN], busy, tag[ROB_SIZE_WIDTH]; x0 is always val=0, busy=0 and is never written.
REQ-004 Reads are combinational (0-cycle) for every slot s and source rs.
REQ-005 Priority, highest first:
- rs==0 -> val 0, not busy
- intra-bundle: an earlier slot j<s with dec_valid&dec_wr_en, rd==rs -> busy=1, tag=dec_rob_id[j]; highest such j wins
- commit bypass: cm_valid[k], cm_rd[k]==rs -> val=cm_val[k], highest k wins; busy cleared if busy and tag==cm_rob_id[k]
- otherwise the stored state
REQ-006 Commit write at posedge, rdy=1: val[cm_rd]<=cm_val for each valid port with rd!=0; busy cleared only when stored tag equals cm_rob_id exactly; same rd on two ports -> highest port index wins.
REQ-007 Rename at posedge, rdy=1, !stall, !flush: each slot with dec_valid&dec_wr_en&rd!=0 sets busy=1, tag=dec_rob_id.
- Overrides a same-cycle commit clear of that register.
- Same rd in two slots -> highest slot wins.
REQ-008 Flush: all busy<=0 and tags<=0; commit value writes of the same cycle still complete; renames are dropped.
REQ-009 stall=1: renames suppressed; commits proceed; read outputs remain valid.
REQ-010 ROB tag wrap-around is handled by exact-equality matching only; no ordering comparisons.

Reset
REQ-011 rst low: immediately (asynchronously) all val<=0, busy<=0, tag<=0, independent of rdy and clk.
REQ-012 Reset mid-operation discards all pending renames; the first posedge after release operates normally.
REQ-013 Output values during reset: all val outputs 0, busy 0, tag 0.

Structure
REQ-014 The shared global parameters package holds XLEN, REG_CNT_WIDTH, ROB_SIZE_WIDTH and the default DISPATCH_WIDTH and COMMIT_WIDTH.
REQ-015 Read-side priority logic is one sub-module, rf_read_port, instantiated 2*DISPATCH_WIDTH times; state update stays in the top.

Verification
REQ-016 Rename then commit: dispatch rd=5, tag=3; next cycle read rs1=5 -> busy=1, tag=3; commit rd=5, tag=3, val=0xAB -> same-cycle read val=0xAB, busy=0; stored busy=0 afterwards.
REQ-017 Stale commit: x5 renamed to tag 3, then to tag 7; commit tag 3, val=0x11 -> val=0x11 stored, busy stays 1, tag=7.
REQ-018 Intra-bundle: slot0 rd=6, tag=2; slot1 rs2=6 -> slot1 busy2=1, tag2=2; slot0 and slot1 both rd=6 (tags 2, 4) -> tag=4 stored.
REQ-019 Dual commit same rd=9: port0 val=1, port1 val=2 -> stored val=2; rename x9 in the same cycle -> busy=1 survives.
REQ-020 Flush with concurrent commit rd=4, val=0x55, and rename rd=8 -> all busy=0, x4=0x55, x8 not busy; rst low mid-run -> all outputs 0 before the next clk edge.
REQ-021 rdy=0 for 3 cycles with commits and renames asserted -> no state change; x0 write attempt -> reads 0.
